traffic_fsm: RTL and testbench
==============================

# traffic_fsm

Main-road/side-road traffic light sequencer that sits directly downstream of the timing-parameter store. It selects which stored interval it needs on `interval`, loads the returned `time_Value` into a 4-bit seconds countdown, and steps the lights through green/yellow/red phases. Phases extend on a vehicle sensor, and an optional pedestrian walk phase is included.

## Interface
Parameters:
- `TICK_IGNORE`, 2, number of clk edges after phase entry before the counter loads (covers the parameter store's registered output).

Ports:
- `clk` input 1: system clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-low reset.
- `sync_Reprogram` input 1: synchronous pulse; restarts the sequence at MG.
- `sec_Tick` input 1: one-clk-wide 1 Hz enable.
- `sensor` input 1: side-road vehicle present, level-sensitive.
- `walk_Request` input 1: pedestrian button pulse; latched internally.
- `time_Value` input 4: interval value returned by the parameter store.
- `interval` output 2: interval select to the parameter store; 00 base, 01 ext, 10 yellow.
- `main_Lights` output 3: {red, yellow, green} for the main road.
- `side_Lights` output 3: {red, yellow, green} for the side road.
- `walk_Light` output 1: pedestrian walk lamp.
- `count_Out` output 4: remaining seconds, for display.

## Operation
- States, with their `interval` code and lights:
  - MG: 00, main 001, side 100.
  - MG_EXT: 01, main 001, side 100.
  - MY: 10, main 010, side 100.
  - SG: 00, main 100, side 001.
  - SG_EXT: 01, main 100, side 001.
  - SY: 10, main 100, side 010.
  - WALK: 01, main 100, side 100, `walk_Light`=1.
- Transitions, taken on phase expiry:
  - MG goes to MG_EXT if `sensor`=1 at expiry, else to MY.
  - MG_EXT goes to MY.
  - MY goes to SG.
  - SG goes to SG_EXT if `sensor`=1 at expiry, else to SY.
  - SG_EXT goes to SY.
  - SY goes to WALK if walk is pending, else to MG.
  - WALK goes to MG.
- Phase entry:
  - `interval` registers on the same edge as the state change.
  - The load-wait counter is set to `TICK_IGNORE`.
  - On the edge where the load-wait reaches 0, the countdown loads `time_Value`.
  - A `time_Value` of 0 loads as 1.
  - `sec_Tick` is ignored during the load-wait.
- Countdown:
  - Decrements on `sec_Tick` after load.
  - Expiry is `sec_Tick` while count==1. On that edge the state changes and the count goes to 0.
- Walk pending:
  - Set by `walk_Request`=1 on any edge.
  - Cleared on the edge entering WALK.
  - A request during WALK stays pending for the next cycle.
- `count_Out` equals the countdown register; it reads 0 during the load-wait.
- Priority: `reset` > `sync_Reprogram` > expiry > tick decrement.
- `sync_Reprogram` forces MG and `interval`=00, restarts the load-wait, and clears walk pending.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state MG, `interval`=00, `main_Lights`=001, `side_Lights`=100.
  - `walk_Light`=0, `count_Out`=0, walk pending 0, load-wait=`TICK_IGNORE`.
- Light outputs are registered decodes of the state and change on the same edge as the state.
- Phase duration is exactly N `sec_Tick`s counted after load, plus `TICK_IGNORE` clks.
- `sensor` is sampled only on the expiry edge of MG and SG.
- Reset asserted mid-phase returns all outputs to their reset values immediately.
- At most one state change per clk.

## Configuration
- `TRAFFIC_WALK_EN` defined:
  - WALK state, walk pending latch, and `walk_Light` are present as above.
- `TRAFFIC_WALK_EN` not defined:
  - `walk_Request` is ignored and `walk_Light` is tied to 0.
  - SY always goes to MG; the WALK state does not exist.

## Test plan
- Reset release, `sensor`=0, `time_Value` modelled as base 6 / ext 3 / yel 2, `sec_Tick` every 4 clk. Required: MG 6 ticks, MY 2, SG 6, SY 2, back to MG; `interval` sequence 00,10,00,10.
- `sensor`=1 held. Required: MG then MG_EXT for 3 ticks (`interval`=01), MY, SG then SG_EXT for 3 ticks, SY.
- `walk_Request` pulse during MG, `TRAFFIC_WALK_EN` defined. Required: after SY, WALK for 3 ticks with `walk_Light`=1 and both roads 100, then MG. The next cycle has no WALK.
- `time_Value`=0 during SG, plus `sec_Tick` asserted during the load-wait. Required: SG lasts exactly 1 tick after load and the load-wait tick is ignored.
- `sync_Reprogram` pulse mid-SG with count=4. Required: next edge is MG, `interval`=00, `count_Out`=0, then load 6.
- `reset`=0 asserted asynchronously mid-MY. Required: outputs immediately go to MG values with `count_Out`=0. Same with `TRAFFIC_WALK_EN` undefined: `walk_Light` stays 0 throughout.

Source files
------------

// File: rtl/traffic_fsm.sv
// Main/side-road traffic light sequencer fed by a registered timing-parameter store.
// Optional pedestrian walk phase is built when TRAFFIC_WALK_EN is defined.
module traffic_fsm #(
  parameter int TICK_IGNORE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_Reprogram,
  input  logic       sec_Tick,
  input  logic       sensor,
  input  logic       walk_Request,
  input  logic [3:0] time_Value,
  output logic [1:0] interval,
  output logic [2:0] main_Lights,
  output logic [2:0] side_Lights,
  output logic       walk_Light,
  output logic [3:0] count_Out
);
  localparam int LW_W = (TICK_IGNORE < 2) ? 1 : $clog2(TICK_IGNORE + 1);
  localparam logic [LW_W-1:0] LW_INIT = LW_W'(TICK_IGNORE);
  localparam logic [LW_W-1:0] LW_ONE  = LW_W'(1);

  localparam logic [1:0] IV_BASE = 2'b00;
  localparam logic [1:0] IV_EXT  = 2'b01;
  localparam logic [1:0] IV_YEL  = 2'b10;
  localparam logic [2:0] L_RED   = 3'b100;
  localparam logic [2:0] L_YEL   = 3'b010;
  localparam logic [2:0] L_GRN   = 3'b001;

  typedef enum logic [2:0] {
    MG, MG_EXT, MY, SG, SG_EXT, SY
`ifdef TRAFFIC_WALK_EN
    , WALK
`endif
  } state_t;

  state_t          state_q, state_d, nxt;
  logic [LW_W-1:0] lw_q, lw_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      iv_d;
  logic [2:0]      main_d, side_d;
  logic            loading, expire;

  // Load-wait covers the store's registered lookup of the new interval.
  assign loading = (lw_q != '0);
  assign expire  = !loading && sec_Tick && (cnt_q == 4'd1);

`ifdef TRAFFIC_WALK_EN
  logic pend_q, pend_d, walk_d;
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_Request;
`endif

  always_comb begin
    nxt = MG;
    case (state_q)
      MG:      nxt = sensor ? MG_EXT : MY;
      MG_EXT:  nxt = MY;
      MY:      nxt = SG;
      SG:      nxt = sensor ? SG_EXT : SY;
      SG_EXT:  nxt = SY;
`ifdef TRAFFIC_WALK_EN
      SY:      nxt = pend_q ? WALK : MG;
`else
      SY:      nxt = MG;
`endif
      default: nxt = MG;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    cnt_d   = cnt_q;
`ifdef TRAFFIC_WALK_EN
    pend_d  = pend_q | walk_Request;
`endif
    if (sync_Reprogram) begin
      state_d = MG;
      lw_d    = LW_INIT;
      cnt_d   = '0;
`ifdef TRAFFIC_WALK_EN
      pend_d  = 1'b0;
`endif
    end else if (loading) begin
      lw_d = lw_q - LW_ONE;
      // A zero interval would never expire, so it runs as one second.
      if (lw_q == LW_ONE) cnt_d = (time_Value == 4'd0) ? 4'd1 : time_Value;
    end else if (expire) begin
      state_d = nxt;
      lw_d    = LW_INIT;
      cnt_d   = '0;
`ifdef TRAFFIC_WALK_EN
      if (nxt == WALK) pend_d = 1'b0;
`endif
    end else if (sec_Tick && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    iv_d   = IV_BASE;
    main_d = L_GRN;
    side_d = L_RED;
`ifdef TRAFFIC_WALK_EN
    walk_d = 1'b0;
`endif
    case (state_d)
      MG:      ;
      MG_EXT:  iv_d = IV_EXT;
      MY:      begin iv_d = IV_YEL; main_d = L_YEL; end
      SG:      begin main_d = L_RED; side_d = L_GRN; end
      SG_EXT:  begin iv_d = IV_EXT; main_d = L_RED; side_d = L_GRN; end
      SY:      begin iv_d = IV_YEL; main_d = L_RED; side_d = L_YEL; end
`ifdef TRAFFIC_WALK_EN
      WALK:    begin iv_d = IV_EXT; main_d = L_RED; side_d = L_RED; walk_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MG;
      lw_q        <= LW_INIT;
      cnt_q       <= '0;
      interval    <= IV_BASE;
      main_Lights <= L_GRN;
      side_Lights <= L_RED;
    end else begin
      state_q     <= state_d;
      lw_q        <= lw_d;
      cnt_q       <= cnt_d;
      interval    <= iv_d;
      main_Lights <= main_d;
      side_Lights <= side_d;
    end
  end

`ifdef TRAFFIC_WALK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      walk_Light <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      walk_Light <= walk_d;
    end
  end
`else
  assign walk_Light = 1'b0;
`endif

  assign count_Out = cnt_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: a phase-level generator predicts each phase,
// a monitor reconstructs phases from the DUT outputs and compares.
module tb_traffic_fsm;
  localparam int TI = 2;
`ifdef TRAFFIC_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sync_Reprogram = 1'b0;
  logic       sec_Tick = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_Request = 1'b0;
  logic [3:0] time_Value = 4'd0;
  logic [1:0] interval;
  logic [2:0] main_Lights, side_Lights;
  logic       walk_Light;
  logic [3:0] count_Out;

  traffic_fsm #(.TICK_IGNORE(TI)) dut (
    .clk(clk), .reset(reset), .sync_Reprogram(sync_Reprogram), .sec_Tick(sec_Tick),
    .sensor(sensor), .walk_Request(walk_Request), .time_Value(time_Value),
    .interval(interval), .main_Lights(main_Lights), .side_Lights(side_Lights),
    .walk_Light(walk_Light), .count_Out(count_Out)
  );

  always #5 clk = ~clk;

  // Parameter store: registered lookup of the requested interval.
  logic [3:0] tv_tab [4];
  always @(posedge clk) time_Value <= tv_tab[interval];

  // Phases: 0 MG, 1 MG_EXT, 2 MY, 3 SG, 4 SG_EXT, 5 SY, 6 WALK
  int iv_of   [7] = '{0, 1, 2, 0, 1, 2, 1};
  int main_of [7] = '{1, 1, 2, 4, 4, 4, 4};
  int side_of [7] = '{4, 4, 4, 1, 1, 2, 4};
  int walk_of [7] = '{0, 0, 0, 0, 0, 0, 1};
  int def_tv  [3] = '{6, 3, 2};

  typedef struct { int ph; int loadv; int ticks; } exp_t;
  exp_t expq[$];

  int n_chk = 0, n_err = 0;
  int cur = 0;
  bit pend = 0, rand_mode = 0, req_pulse = 0;
  int gap_fix = 3, sn_hold = 0, req_pct = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sig_of(input int ph);
    return (iv_of[ph] << 7) | (main_of[ph] << 4) | (side_of[ph] << 1) | walk_of[ph];
  endfunction

  function automatic int next_ph(input int ph, input bit sn, input bit pd);
    case (ph)
      0: return sn ? 1 : 2;
      1: return 2;
      2: return 3;
      3: return sn ? 4 : 5;
      4: return 5;
      5: return (WALK_EN && pd) ? 6 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic bit pick_req();
    if (req_pulse) begin req_pulse = 0; return 1'b1; end
    return (req_pct != 0) && ($urandom_range(0, 99) < req_pct);
  endfunction

  function automatic bit rnd_sn();
    return (sn_hold >= 0) ? sn_hold[0] : 1'($urandom_range(0, 1));
  endfunction

  function automatic int gap();
    return (gap_fix >= 0) ? gap_fix : int'($urandom_range(0, 2));
  endfunction

  // Sets the inputs seen by the next rising edge.
  task automatic drive(input bit tk, input bit sn, input bit wr, input bit sr);
    @(negedge clk); #1;
    sec_Tick = tk; sensor = sn; walk_Request = wr; sync_Reprogram = sr;
    if (wr) pend = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_interval"}, int'(interval), 0);
    check({tag, "_main"}, int'(main_Lights), 1);
    check({tag, "_side"}, int'(side_Lights), 4);
    check({tag, "_walk"}, int'(walk_Light), 0);
    check({tag, "_count"}, int'(count_Out), 0);
  endtask

  // One phase from entry to expiry; kind 1 aborts with sync, kind 2 with reset.
  task automatic step(input int tv, input int sn_exp, input bit lwt, input int abort_at, input int kind);
    int t, need, iv, nx;
    bit sn;
    exp_t e;
    iv = iv_of[cur];
    t = (tv < 0) ? def_tv[iv] : tv;
    need = (t == 0) ? 1 : t;
    tv_tab[iv] = 4'(t);
    sn = (sn_exp < 0) ? 1'($urandom_range(0, 1)) : sn_exp[0];
    for (int i = 0; i < TI; i++)
      drive(lwt | (rand_mode && $urandom_range(0, 3) == 0), rnd_sn(), pick_req(), 1'b0);
    e.ph = cur; e.loadv = need; e.ticks = need;
    nx = 0;
    for (int k = 0; k < need; k++) begin
      if (kind != 0 && k == abort_at) break;
      repeat (gap()) drive(1'b0, rnd_sn(), pick_req(), 1'b0);
      if (k == need - 1) begin
        nx = next_ph(cur, sn, pend);
        if (nx == 6) pend = 1'b0;
        drive(1'b1, sn, 1'b0, 1'b0);
      end else begin
        drive(1'b1, rnd_sn(), pick_req(), 1'b0);
      end
    end
    if (kind == 1) begin
      e.ticks = abort_at;
      expq.push_back(e);
      drive(1'b0, rnd_sn(), 1'b0, 1'b1);
      pend = 1'b0;
      nx = 0;
    end else if (kind == 2) begin
      e.ticks = abort_at;
      expq.push_back(e);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      #1 check_reset_outputs("async_reset");
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      pend = 1'b0;
      nx = 0;
    end else begin
      expq.push_back(e);
    end
    cur = nx;
  endtask

  // Monitor: rebuilds each phase from the outputs and scores it when it ends.
  int m_open = 0, m_sig = 0, m_ticks = 0, m_lwc = 0, m_load = 0, prev_cnt = 0;

  task automatic close_phase();
    exp_t e;
    if (expq.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL phase_unexpected: got outputs %0h, required no phase end at %0t", m_sig, $time);
      return;
    end
    e = expq.pop_front();
    check("phase_outputs", m_sig, sig_of(e.ph));
    check("phase_load", m_load, e.loadv);
    check("phase_ticks", m_ticks, e.ticks);
    check("phase_loadwait", m_lwc, TI);
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (m_open != 0) close_phase();
      m_open = 0;
      prev_cnt = 0;
    end else begin
      if (m_open != 0 && sec_Tick && prev_cnt != 0) m_ticks++;
      if (m_open != 0 && int'({interval, main_Lights, side_Lights, walk_Light}) != m_sig) begin
        close_phase();
        m_open = 0;
      end
      if (m_open == 0) begin
        m_open = 1;
        m_sig = int'({interval, main_Lights, side_Lights, walk_Light});
        m_ticks = 0; m_lwc = 0; m_load = 0;
      end
      if (count_Out == 4'd0) m_lwc++;
      else begin
        if (m_load == 0) m_load = int'(count_Out);
        check("count_out", int'(count_Out), m_load - m_ticks);
      end
      prev_cnt = int'(count_Out);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    tv_tab[0] = 4'd6; tv_tab[1] = 4'd3; tv_tab[2] = 4'd2; tv_tab[3] = 4'd0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(posedge clk);
    #2 reset = 1'b1;

    // Plain cycle, sensor low, tick every 4 clk
    repeat (4) step(-1, 0, 1'b0, -1, 0);
    // Sensor held high: both extensions
    sn_hold = 1;
    repeat (6) step(-1, 1, 1'b0, -1, 0);
    sn_hold = 0;
    // Walk request during MG
    req_pulse = 1'b1;
    repeat (4) step(-1, 0, 1'b0, -1, 0);
    if (cur == 6) step(-1, 0, 1'b0, -1, 0);
    repeat (4) step(-1, 0, 1'b0, -1, 0);
    // Zero interval in SG with ticks during the load-wait
    while (cur != 3) step(-1, 0, 1'b0, -1, 0);
    step(0, 0, 1'b1, -1, 0);
    // Reprogram mid-SG at count 4, then MG reloads 6
    while (cur != 3) step(-1, 0, 1'b0, -1, 0);
    step(6, 0, 1'b0, 2, 1);
    step(-1, 0, 1'b0, -1, 0);

    // Randomized traffic
    rand_mode = 1'b1; gap_fix = -1; sn_hold = -1; req_pct = 12;
    repeat (60) step(int'($urandom_range(0, 7)), -1, 1'($urandom_range(0, 1)), -1, 0);

    // Asynchronous reset mid-MY
    while (cur != 2) step(int'($urandom_range(0, 7)), -1, 1'b0, -1, 0);
    step(-1, -1, 1'b0, 1, 2);
    step(-1, -1, 1'b0, -1, 0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
